// File: rtl/paralelo_serial_tx.sv
// Transmit end of the PHY serial link: serializes parallel words MSB-first, comma fill when idle.
// Latency: MSB of a word loaded at edge t is on data_out right after edge t; LSB after t+WIDTH-1.
// Backpressure: no stall; a word is taken only on a load edge flagged by ready_out, otherwise comma.
//
// Ports:
//   clk            single clock, all logic on posedge
//   reset          asynchronous, active-low; clears all state at once
//   data_in        parallel word, sampled only on a load edge
//   valid_in       data_in holds a word to send, sampled only on a load edge
//   data_out       serial line (registered)
//   ready_out      next posedge is a load edge that accepts data (decode of registers)
//   data_frame_out 1 while data_out carries a user word (registered)
//   sync_done      1 once the comma preamble has finished (registered)
module paralelo_serial_tx #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC,
  parameter int               N_SYNC   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             data_out,
  output logic             ready_out,
  output logic             data_frame_out,
  output logic             sync_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // One extra value of headroom so N_SYNC==1 still yields a legal width.
  localparam int SW = $clog2(N_SYNC + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SYNC = SW'(N_SYNC - 1);

  typedef enum logic {
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [SW-1:0]    r_sync_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_data_out;
  logic             r_frame;
  logic             r_sync_done;

  logic             w_load;
  logic             w_take;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    w_bit_idx;

  assign w_load    = (r_cnt == '0);
  // Inputs only matter once the preamble is done; in SYNC every word is a comma.
  assign w_take    = (r_state == ST_RUN) && valid_in;
  assign w_word    = w_take ? data_in : IDLE_SYM;
  // Bit position sent at a non-load edge: counter k selects sreg[WIDTH-1-k].
  assign w_bit_idx = LAST_BIT - r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SYNC;
      r_cnt       <= '0;
      r_sync_cnt  <= '0;
      r_sreg      <= '0;
      r_data_out  <= 1'b0;
      r_frame     <= 1'b0;
      r_sync_done <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == LAST_BIT) ? '0 : r_cnt + CW'(1);

      if (w_load) begin
        // MSB goes straight out so the new word starts on the very next bit.
        r_sreg     <= w_word;
        r_data_out <= w_word[WIDTH-1];
        r_frame    <= w_take;

        if (r_state == ST_SYNC) begin
          r_sync_cnt <= r_sync_cnt + SW'(1);
          if (r_sync_cnt == LAST_SYNC) begin
            r_state     <= ST_RUN;
            r_sync_done <= 1'b1;
          end
        end
      end else begin
        r_data_out <= r_sreg[w_bit_idx];
      end
    end
  end

  assign data_out       = r_data_out;
  assign data_frame_out = r_frame;
  assign sync_done      = r_sync_done;
  assign ready_out      = (r_state == ST_RUN) && w_load;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Bench for paralelo_serial_tx: directed word-level scenarios with literal expectations,
// plus a word-level reference model compared against every output on every clock.
module tb_paralelo_serial_tx;

  localparam int         WIDTH  = 8;
  localparam logic [7:0] IDLE   = 8'hBC;
  localparam int         N_SYNC = 4;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       data_out;
  logic       ready_out;
  logic       data_frame_out;
  logic       sync_done;

  int checks;
  int errors;

  // Reference model state: edges since reset release, words started, current word.
  int         m_edges;
  int         m_words;
  logic [7:0] m_word;
  logic       m_frame;
  logic       e_do, e_frame, e_sync, e_rdy;

  paralelo_serial_tx #(
    .WIDTH   (WIDTH),
    .IDLE_SYM(IDLE),
    .N_SYNC  (N_SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .data_out      (data_out),
    .ready_out     (ready_out),
    .data_frame_out(data_frame_out),
    .sync_done     (sync_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_words = 0;
    m_word  = '0;
    m_frame = 1'b0;
    e_do    = 1'b0;
    e_frame = 1'b0;
    e_sync  = 1'b0;
    e_rdy   = 1'b0;
  endtask

  // Every WIDTH-th edge after release starts a new word; words after the
  // first N_SYNC carry user data when valid_in is high at that edge.
  task automatic model_edge();
    if (m_edges % WIDTH == 0) begin
      if (m_words >= N_SYNC && valid_in) begin
        m_word  = data_in;
        m_frame = 1'b1;
      end else begin
        m_word  = IDLE;
        m_frame = 1'b0;
      end
      m_words++;
    end
    e_do    = m_word[WIDTH-1-(m_edges % WIDTH)];
    e_frame = m_frame;
    e_sync  = (m_words >= N_SYNC);
    m_edges++;
    e_rdy   = (m_words >= N_SYNC) && (m_edges % WIDTH == 0);
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    chk("m_data_out", {31'd0, data_out}, {31'd0, e_do});
    chk("m_frame", {31'd0, data_frame_out}, {31'd0, e_frame});
    chk("m_sync_done", {31'd0, sync_done}, {31'd0, e_sync});
    chk("m_ready", {31'd0, ready_out}, {31'd0, e_rdy});
  endtask

  // Collect one full word from the line; optionally change inputs mid-frame.
  task automatic get_word(output logic [7:0] w, output logic f, input int chg_at,
                          input logic [7:0] cd, input logic cv);
    w = '0;
    f = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      w = {w[6:0], data_out};
      f = f & data_frame_out;
      if (i + 1 == chg_at) begin
        data_in  = cd;
        valid_in = cv;
      end
    end
  endtask

  task automatic restart();
    reset = 1'b0;
    #1;
    model_reset();
    tick();
    reset = 1'b1;
  endtask

  logic [7:0] w8, wa, wb;
  logic       f;
  logic       v;
  logic [7:0] d;

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    model_reset();

    repeat (2) tick();
    chk("rst_data_out", {31'd0, data_out}, 32'd0);
    chk("rst_ready", {31'd0, ready_out}, 32'd0);
    chk("rst_frame", {31'd0, data_frame_out}, 32'd0);
    chk("rst_sync", {31'd0, sync_done}, 32'd0);

    // 1: comma preamble and idle fill
    reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      get_word(w8, f, -1, 8'h00, 1'b0);
      chk("t1_word", {24'd0, w8}, 32'hBC);
      chk("t1_frame", {31'd0, f}, 32'd0);
      if (k == 3) begin
        chk("t1_sync_w3", {31'd0, sync_done}, 32'd0);
        chk("t1_ready_w3", {31'd0, ready_out}, 32'd0);
      end
      if (k >= 4) begin
        chk("t1_sync", {31'd0, sync_done}, 32'd1);
        chk("t1_ready", {31'd0, ready_out}, 32'd1);
      end
    end

    // 2: valid during SYNC is ignored, first ready edge takes the word
    restart();
    valid_in = 1'b1;
    data_in  = 8'hA5;
    for (int k = 1; k <= 4; k++) begin
      get_word(w8, f, -1, 8'h00, 1'b0);
      chk("t2_sync_word", {24'd0, w8}, 32'hBC);
      chk("t2_sync_frame", {31'd0, f}, 32'd0);
    end
    get_word(w8, f, -1, 8'h00, 1'b0);
    chk("t2_word", {24'd0, w8}, 32'hA5);
    chk("t2_frame", {31'd0, f}, 32'd1);

    // 3: back-to-back words, then comma after valid drops
    data_in = 8'h3C;
    get_word(wa, f, -1, 8'h00, 1'b0);
    chk("t3_frame_a", {31'd0, f}, 32'd1);
    data_in = 8'hC3;
    get_word(wb, f, -1, 8'h00, 1'b0);
    chk("t3_frame_b", {31'd0, f}, 32'd1);
    chk("t3_stream", {16'd0, wa, wb}, 32'h0000_3CC3);
    valid_in = 1'b0;
    get_word(w8, f, -1, 8'h00, 1'b0);
    chk("t3_idle", {24'd0, w8}, 32'hBC);
    chk("t3_idle_frame", {31'd0, f}, 32'd0);

    // 4: inputs change mid-frame without corrupting it
    data_in  = 8'h0F;
    valid_in = 1'b1;
    get_word(w8, f, 3, 8'hFF, 1'b0);
    chk("t4_word", {24'd0, w8}, 32'h0F);
    chk("t4_frame", {31'd0, f}, 32'd1);
    get_word(w8, f, -1, 8'h00, 1'b0);
    chk("t4_next_idle", {24'd0, w8}, 32'hBC);
    valid_in = 1'b1;
    get_word(w8, f, -1, 8'h00, 1'b0);
    chk("t4_next_ff", {24'd0, w8}, 32'hFF);
    chk("t4_next_frame", {31'd0, f}, 32'd1);

    // 5: asynchronous reset in the middle of a data frame
    data_in = 8'h96;
    repeat (5) tick();
    chk("t5_pre_frame", {31'd0, data_frame_out}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_dout", {31'd0, data_out}, 32'd0);
    chk("t5_async_frame", {31'd0, data_frame_out}, 32'd0);
    chk("t5_async_sync", {31'd0, sync_done}, 32'd0);
    chk("t5_async_ready", {31'd0, ready_out}, 32'd0);
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      get_word(w8, f, -1, 8'h00, 1'b0);
      chk("t5_sync_word", {24'd0, w8}, 32'hBC);
      chk("t5_ready", {31'd0, ready_out}, (k == 4) ? 32'd1 : 32'd0);
    end
    get_word(w8, f, -1, 8'h00, 1'b0);
    chk("t5_word", {24'd0, w8}, 32'h96);
    chk("t5_frame", {31'd0, f}, 32'd1);

    // 6: random words, every WIDTH bits must recover the accepted word
    for (int n = 0; n < 1000; n++) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      valid_in = v;
      data_in  = d;
      get_word(w8, f, -1, 8'h00, 1'b0);
      chk("t6_word", {24'd0, w8}, {24'd0, (v ? d : IDLE)});
      chk("t6_frame", {31'd0, f}, {31'd0, v});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
